// File: rtl/prio_arbiter.sv
// Registered request arbiter with fixed-priority and round-robin modes.
// A grant is held until the consumer accepts it; accepts can stream one grant per clock.
module prio_arbiter #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_onehot
);

    // state | meaning
    // IDLE  | no grant registered, outputs zero
    // HOLD  | grant registered and shown until accepted
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   code_d;
    logic [N-1:0]   onehot_d;
    logic [W-1:0]   ptr_q;
    logic [W-1:0]   code_inc;
    logic [W-1:0]   start_idx;
    logic [W-1:0]   fix_code;
    logic [W-1:0]   rr_code;
    logic [W-1:0]   winner;
    logic [W:0]     rr_sum;
    logic           accept;
    logic           any_req;

    assign out_valid = (state_q == HOLD);
    assign accept    = out_valid & out_ready;
    assign any_req   = |req;
    assign code_inc  = (out_code == W'(N - 1)) ? '0 : out_code + W'(1);
    assign start_idx = accept ? code_inc : ptr_q;

    always_comb begin
        fix_code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) fix_code = W'(i);
        end
    end

    // Walk the scan order backwards so the earliest set bit is written last.
    always_comb begin
        rr_code = '0;
        rr_sum  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_sum = {1'b0, start_idx} + (W + 1)'(k);
            if (rr_sum >= (W + 1)'(N)) rr_sum = rr_sum - (W + 1)'(N);
            if (req[rr_sum[W-1:0]]) rr_code = rr_sum[W-1:0];
        end
    end

    assign winner = mode ? rr_code : fix_code;

    always_comb begin
        state_d  = state_q;
        code_d   = out_code;
        onehot_d = out_onehot;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = HOLD;
                    code_d   = winner;
                    onehot_d = {{(N - 1){1'b0}}, 1'b1} << winner;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (any_req) begin
                        code_d   = winner;
                        onehot_d = {{(N - 1){1'b0}}, 1'b1} << winner;
                    end else begin
                        state_d  = IDLE;
                        code_d   = '0;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                code_d   = '0;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_code   <= '0;
            out_onehot <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_code   <= code_d;
            out_onehot <= onehot_d;
            if (accept) ptr_q <= code_inc;
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed scoreboard bench for prio_arbiter: an 8-way instance and a 5-way
// instance to exercise pointer wrap at a non-power-of-2 width.
module tb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] out_onehot;

    logic       rst5 = 1'b1;
    logic [4:0] req5 = '0;
    logic       mode5 = 1'b1;
    logic       ready5 = 1'b0;
    logic       valid5;
    logic [2:0] code5;
    logic [4:0] onehot5;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string tag;
        logic  v;
        int    code;
    } exp_t;

    exp_t sb[$];

    prio_arbiter #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .out_ready(out_ready),
        .out_valid(out_valid), .out_code(out_code), .out_onehot(out_onehot)
    );

    prio_arbiter #(.N(5)) dut5 (
        .clk(clk), .rst(rst5), .req(req5), .mode(mode5), .out_ready(ready5),
        .out_valid(valid5), .out_code(code5), .out_onehot(onehot5)
    );

    always #5 clk = ~clk;

    task automatic check8();
        exp_t e;
        logic [7:0] eoh;
        e = sb.pop_front();
        eoh = e.v ? (8'h01 << e.code) : 8'h00;
        compared++;
        assert (out_valid === e.v) else begin
            mismatched++;
            $error("FAIL %s valid: observed %0b expected %0b", e.tag, out_valid, e.v);
        end
        compared++;
        assert (out_code === 3'(e.code)) else begin
            mismatched++;
            $error("FAIL %s code: observed %0d expected %0d", e.tag, out_code, e.code);
        end
        compared++;
        assert (out_onehot === eoh) else begin
            mismatched++;
            $error("FAIL %s onehot: observed %h expected %h", e.tag, out_onehot, eoh);
        end
    endtask

    task automatic check5();
        exp_t e;
        logic [4:0] eoh;
        e = sb.pop_front();
        eoh = e.v ? (5'h01 << e.code) : 5'h00;
        compared++;
        assert (valid5 === e.v) else begin
            mismatched++;
            $error("FAIL %s valid: observed %0b expected %0b", e.tag, valid5, e.v);
        end
        compared++;
        assert (code5 === 3'(e.code)) else begin
            mismatched++;
            $error("FAIL %s code: observed %0d expected %0d", e.tag, code5, e.code);
        end
        compared++;
        assert (onehot5 === eoh) else begin
            mismatched++;
            $error("FAIL %s onehot: observed %h expected %h", e.tag, onehot5, eoh);
        end
    endtask

    // Drive one cycle on the 8-way instance and check the registered result.
    task automatic step(input string tag, input logic r, input logic m, input logic rdy,
                        input logic [7:0] rq, input logic ev, input int ec);
        rst = r; mode = m; out_ready = rdy; req = rq;
        sb.push_back('{tag, ev, ec});
        @(posedge clk); #1;
        check8();
    endtask

    task automatic step5(input string tag, input logic r, input logic rdy,
                         input logic [4:0] rq, input logic ev, input int ec);
        rst5 = r; ready5 = rdy; req5 = rq;
        sb.push_back('{tag, ev, ec});
        @(posedge clk); #1;
        check5();
    endtask

    initial begin
        // reset wins over active request and ready
        step("rst_prio",   1, 1, 1, 8'hFF, 0, 0);
        step("idle_noreq", 0, 0, 1, 8'h00, 0, 0);
        step("idle_noreq2",0, 0, 1, 8'h00, 0, 0);

        // fixed priority, repeated grant while held
        step("fix_a4_0",   0, 0, 1, 8'hA4, 1, 2);
        step("fix_a4_1",   0, 0, 1, 8'hA4, 1, 2);
        step("fix_a4_2",   0, 0, 1, 8'hA4, 1, 2);
        step("drain",      0, 0, 1, 8'h00, 0, 0);
        step("drain_idle", 0, 0, 1, 8'h00, 0, 0);

        // round-robin sweep from ptr=0
        step("rr_rst",     1, 1, 1, 8'h00, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            step($sformatf("rr_ff_%0d", i), 0, 1, 1, 8'hFF, 1, i % 8);
        end

        // hold: code 5 stays while ready=0 and req changes
        step("hold_load",  0, 0, 1, 8'h20, 1, 5);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("hold_%0d", i), 0, i % 2, 0, 8'h01, 1, 5);
        end
        step("hold_rel",   0, 0, 1, 8'h01, 1, 0);

        // mode switch: ptr=6 -> fixed grants 0 -> RR resumes from 1
        step("msw_fix",    0, 0, 1, 8'h41, 1, 0);
        step("msw_rr",     0, 1, 1, 8'h41, 1, 6);
        step("msw_rr2",    0, 1, 1, 8'h41, 1, 0);
        step("msw_drain",  0, 1, 1, 8'h00, 0, 0);

        // reset in HOLD discards the grant and clears ptr
        step("hold3_load", 0, 0, 0, 8'h08, 1, 3);
        step("hold3_keep", 0, 0, 0, 8'h08, 1, 3);
        step("rst_hold",   1, 0, 1, 8'h08, 0, 0);
        step("post_rst",   0, 1, 0, 8'hFF, 1, 0);
        step("post_rst2",  0, 1, 1, 8'hFF, 1, 1);

        // N=5 round-robin wrap
        step5("n5_rst",    1, 1, 5'b10001, 0, 0);
        step5("n5_0",      0, 1, 5'b10001, 1, 0);
        step5("n5_1",      0, 1, 5'b10001, 1, 4);
        step5("n5_2",      0, 1, 5'b10001, 1, 0);
        step5("n5_3",      0, 1, 5'b10001, 1, 4);
        step5("n5_wrap",   0, 1, 5'b00010, 1, 1);
        step5("n5_drain",  0, 1, 5'b00000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
